// File: rtl/rst_sequencer.sv
// Ordered multi-channel reset sequencer: synchronises the board reset, then releases
// o_rst[0..NUM_CH-1] one by one. Optional ready-timeout retry: define RST_SEQ_TIMEOUT_EN.
module rst_sequencer #(
  parameter int                NUM_CH         = 3,
  parameter int                SYNC_STAGES    = 2,
  parameter int                HOLD_CYCLES    = 16,
  parameter int                CNT_W          = 24,
  parameter logic [NUM_CH-1:0] READY_MASK     = NUM_CH'(1),
  parameter int                TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk_166_67_mhz,
  input  logic              dram_rstx_async,
  input  logic              i_soft_rst,
  input  logic [NUM_CH-1:0] i_ready,
  output logic [NUM_CH-1:0] o_rst,
  output logic              o_done,
  output logic [2:0]        o_state,
  output logic              o_timeout
);

  localparam int               IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_CH - 1);

`ifdef RST_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    WAIT_RDY = 2'd2,
    DONE     = 2'd3
  } state_t;

  // Board reset synchroniser: async set, clocks zeros in after release.
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rst_int;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], 1'b0};
  end

  always_ff @(posedge clk_166_67_mhz or negedge dram_rstx_async) begin
    if (!dram_rstx_async) sync_q <= '1;
    else                  sync_q <= sync_d;
  end

  assign rst_int = sync_q[SYNC_STAGES-1];

  logic [NUM_CH-1:0] rdy_s;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rdy_sync
      logic [SYNC_STAGES-1:0] chain_q, chain_d;

      always_comb begin
        chain_d = {chain_q[SYNC_STAGES-2:0], i_ready[gi]};
      end

      always_ff @(posedge clk_166_67_mhz or negedge dram_rstx_async) begin
        if (!dram_rstx_async) chain_q <= '0;
        else                  chain_q <= chain_d;
      end

      assign rdy_s[gi] = chain_q[SYNC_STAGES-1];
    end
  endgenerate

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0] rst_q, rst_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;

  always_ff @(posedge clk_166_67_mhz or negedge dram_rstx_async) begin
    if (!dram_rstx_async) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      rst_q     <= '1;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      rst_q     <= rst_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    rst_d     = rst_q;
    done_d    = done_q;
    timeout_d = timeout_q;

    if (i_soft_rst) begin
      state_d   = IDLE;
      idx_d     = '0;
      cnt_d     = '0;
      rst_d     = '1;
      done_d    = 1'b0;
      timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!rst_int) begin
            state_d = HOLD;
            idx_d   = '0;
            cnt_d   = '0;
          end
        end

        HOLD: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == HOLD_LAST) begin
            rst_d[idx_q] = 1'b0;
            cnt_d        = '0;
            if (READY_MASK[idx_q]) begin
              state_d = WAIT_RDY;
            end else if (idx_q == IDX_LAST) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end

        WAIT_RDY: begin
          if (rdy_s[idx_q]) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = HOLD;
            end
          end else if (TO_EN) begin
            cnt_d = cnt_q + 1'b1;
            // Stuck ready: flag it and retry the whole sequence from channel 0.
            if (cnt_q == TO_LAST) begin
              timeout_d = 1'b1;
              rst_d     = '1;
              idx_d     = '0;
              cnt_d     = '0;
              state_d   = HOLD;
            end
          end
        end

        DONE: begin
          done_d = 1'b1;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign o_rst     = rst_q;
  assign o_done    = done_q;
  assign o_state   = {1'b0, state_q};
  assign o_timeout = timeout_q;

endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Parametrised successor to the single-channel two-flop DRAM reset synchroniser.
- Synchronises one async active-low board reset (resetn & PLL locked) into NUM_CH active-high reset outputs.
- Releases the outputs strictly in index order. Each release follows a programmable hold time.
- Channels selected by READY_MASK additionally gate the next release on a ready input, e.g. DRAM init_calib_complete before the core and peripherals come out of reset.

Parameters:
- NUM_CH, 3: number of reset output channels, 1..8.
- SYNC_STAGES, 2: flops in the reset synchroniser and in each ready synchroniser, 2..4.
- HOLD_CYCLES, 16: cycles spent in HOLD before each channel is released, 1..2^CNT_W-1.
- CNT_W, 24: width of the shared hold/timeout counter.
- READY_MASK, 3'b001: bit i set means channel i must see i_ready[i] high before channel i+1 is processed.
- TIMEOUT_CYCLES, 1_000_000: WAIT_RDY limit, used only with the optional feature; must be < 2^CNT_W.

Ports:
- clk_166_67_mhz  in  1  sequencer clock.
- dram_rstx_async  in  1  reset, asynchronous, active-low.
- i_soft_rst  in  1  synchronous level request that re-runs the full sequence.
- i_ready  in  NUM_CH  per-channel ready, asynchronous, synchronised internally.
- o_rst  out  NUM_CH  active-high resets, registered.
- o_done  out  1  all channels released and all masked readies seen, registered.
- o_state  out  3  FSM state encoding, for debug (ILA).
- o_timeout  out  1  sticky ready-timeout flag.

Behaviour:
- Reset synchroniser: a SYNC_STAGES-deep chain is async-set by dram_rstx_async low and clocks in 0 after release. rst_int is the last stage.
- While dram_rstx_async is low, all outputs take their reset values immediately (async): o_rst all ones, o_done 0, o_timeout 0, FSM in IDLE, idx 0, counter 0.
- i_ready[i] passes through its own SYNC_STAGES chain, giving rdy_s[i]. Those chains are reset to 0.
- FSM states and encodings: IDLE=0, HOLD=1, WAIT_RDY=2, DONE=3.
- IDLE: stays while rst_int=1 or i_soft_rst=1. Otherwise moves to HOLD with idx=0 and cnt=0.
- HOLD: cnt increments every cycle. When cnt==HOLD_CYCLES-1:
  - o_rst[idx] is cleared on that same edge.
  - If READY_MASK[idx]=1, go to WAIT_RDY with cnt=0.
  - Else, if idx==NUM_CH-1, go to DONE.
  - Else idx++, cnt=0, stay in HOLD.
- WAIT_RDY: when rdy_s[idx]=1, either go to DONE (idx==NUM_CH-1) or do idx++ and cnt=0 and go to HOLD.
- DONE: o_done=1, registered on the entry edge. Ready deassertion in DONE is ignored.
- Release timing: o_rst[0] falls on the (SYNC_STAGES+1+HOLD_CYCLES)th rising edge after dram_rstx_async rises. Channel k>0 falls HOLD_CYCLES cycles after channel k-1, plus the WAIT_RDY residence time when READY_MASK[k-1]=1.
- Ordering invariant: o_rst[j] is never 0 while o_rst[i] is 1 for any i<j.
- Soft reset: i_soft_rst=1 in any state, sampled at an edge, does the following on that edge:
  - sets o_rst to all ones and o_done to 0, idx 0, cnt 0;
  - moves the FSM to IDLE;
  - clears o_timeout.
  The sequence restarts one cycle after i_soft_rst falls.
- Async reset mid-sequence: outputs return to reset values immediately. The sequence then restarts from the synchroniser.
- Ready already high on entry to WAIT_RDY: WAIT_RDY exits after exactly one cycle.
- NUM_CH=1: DONE is reached right after channel 0's release, or after its ready when masked.

Optional Feature:
- Macro: RST_SEQ_TIMEOUT_EN.
- Defined: in WAIT_RDY, cnt increments every cycle. If cnt reaches TIMEOUT_CYCLES-1 without rdy_s[idx]=1:
  - o_timeout is set (sticky) on that edge;
  - o_rst is set back to all ones, idx=0, cnt=0;
  - the FSM goes to HOLD, giving an automatic retry of the whole sequence.
  - o_timeout clears only on async reset or i_soft_rst.
- Undefined: WAIT_RDY waits indefinitely and o_timeout is tied to 0.

Test Plan:
- Defaults, i_ready=3'b111 held high; release dram_rstx_async -> o_rst[0] falls at edge 19, o_rst[1] at edge 36 (two-flop ready sync already settled, one WAIT_RDY cycle), o_rst[2] at edge 52; o_done=1 at edge 52.
- i_ready[0]=0 held; release reset -> o_rst=3'b110 stays for 5000 cycles, o_state=2. Raise i_ready[0] at cycle T -> o_rst[1] falls at T+SYNC_STAGES+1+HOLD_CYCLES = T+19.
- Pulse dram_rstx_async low for 1 ns mid-HOLD of channel 1 -> o_rst=3'b111 and o_done=0 asynchronously; full sequence repeats with the same timing as test 1.
- i_soft_rst high for 3 cycles while in DONE -> o_rst=3'b111 on the next edge; o_rst[0] falls HOLD_CYCLES+1 = 17 edges after i_soft_rst falls.
- RST_SEQ_TIMEOUT_EN with TIMEOUT_CYCLES=100, i_ready=0 -> o_timeout=1 exactly 100 cycles after entering WAIT_RDY; o_rst returns to 3'b111 and o_rst[0] falls again 16 cycles later; retries repeat every 116 cycles.
- Random i_ready toggling and soft resets over 10^5 cycles -> ordering invariant assertion never fires; o_done=1 implies o_rst=0.
